// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a byte FIFO: start bit, 8 data bits LSB first, stop bit(s).
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
module fifo_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       tx_en,
  input  logic [7:0] fifo_data,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic       txd,
  output logic       busy,
  output logic       frame_done
);

  localparam int unsigned   BW        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;
`endif

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          txd_q, txd_d;
  logic          rd_q, rd_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    rd_d    = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    bit_end = (baud_q == BAUD_LAST);
    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        txd_d  = 1'b1;
        busy_d = 1'b0;
        if (!fifo_empty && tx_en) begin
          state_d = START;
          sh_d    = fifo_data;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
          rd_d    = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = ^fifo_data;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          txd_d   = sh_q[0];
        end
      end
      DATA: begin
        // txd is registered, so the next bit is taken from sh_q[1] before the shift lands
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            txd_d   = par_q;
`else
            state_d = STOP;
            txd_d   = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
            sh_d  = {1'b0, sh_q[7:1]};
            txd_d = sh_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = IDLE;
            bit_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (clear) begin
      state_d = IDLE;
      baud_d  = '0;
      bit_d   = '0;
      txd_d   = 1'b1;
      busy_d  = 1'b0;
      rd_d    = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      rd_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      rd_q    <= rd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign fifo_rd    = rd_q;
  assign txd        = txd_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench for fifo_uart_tx: stimulus queues expected frames, a txd monitor checks them.
module tb_fifo_uart_tx;

  localparam int C  = 4;
  localparam int SB = 1;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int NBITS = 9 + PB + SB;
  localparam int FL    = NBITS * C;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic       tx_en = 1'b0;
  logic [7:0] fifo_data;
  logic       fifo_empty;
  logic       fifo_rd, txd, busy, frame_done;

  fifo_uart_tx #(.CLKS_PER_BIT(C), .STOP_BITS(SB)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .tx_en      (tx_en),
    .fifo_data  (fifo_data),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .txd        (txd),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // FIFO model: head word is combinational, pop on fifo_rd at the clock edge
  logic [7:0] mem [16];
  int wr_ptr  = 0;
  int rd_ptr  = 0;
  int pop_cnt = 0;
  int cyc     = 0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_data  = mem[rd_ptr[3:0]];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd === 1'b1) begin
      pop_cnt <= pop_cnt + 1;
      if (fifo_empty) begin
        n_checks++;
        n_fail++;
        $display("FAIL pop_while_empty: got fifo_rd=1 expected 0 at cycle %0d", cyc);
      end else begin
        rd_ptr <= rd_ptr + 1;
      end
    end
  end

  task automatic push_fifo(input logic [7:0] d);
    mem[wr_ptr[3:0]] = d;
    wr_ptr++;
  endtask

  typedef struct {
    logic [7:0] d;
    logic       par;
    int         gap;
  } exp_t;

  exp_t sb[$];

  task automatic expect_frame(input logic [7:0] d, input logic par, input int gap);
    exp_t e;
    e.d = d;
    e.par = par;
    e.gap = gap;
    sb.push_back(e);
  endtask

  logic mon_en = 1'b1;
  logic m_act = 1'b0;
  logic m_ghost = 1'b0;
  int   m_k = 0;
  int   last_end = 0;
  exp_t m_e;
  logic m_bits [16];
  logic bit_err, busy_err, rd_err;

  always @(negedge clk) begin
    if (!mon_en || !rst_n) begin
      m_act = 1'b0;
      m_ghost = 1'b0;
    end else begin
      if (!m_act) begin
        if (txd === 1'b0) begin
          m_act = 1'b1;
          m_k = 0;
          bit_err = 1'b0;
          busy_err = 1'b0;
          rd_err = 1'b0;
          if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            m_ghost = 1'b1;
            $display("FAIL unexpected_frame: got start bit at cycle %0d expected none", cyc);
          end else begin
            m_e = sb.pop_front();
            for (int i = 0; i < 16; i++) m_bits[i] = 1'b1;
            m_bits[0] = 1'b0;
            for (int i = 0; i < 8; i++) m_bits[i+1] = m_e.d[i];
`ifdef UART_TX_PARITY_EN
            m_bits[9] = m_e.par;
`endif
            if (m_e.gap >= 0) check($sformatf("gap_before_%02h", m_e.d), cyc - last_end, m_e.gap);
            check($sformatf("pop_at_start_%02h", m_e.d), fifo_rd, 1);
          end
        end else if (frame_done !== 1'b0) begin
          check("spurious_frame_done", frame_done, 0);
        end
      end
      if (m_act) begin
        if (m_k < FL) begin
          if (txd !== m_bits[m_k / C]) bit_err = 1'b1;
          if (busy !== 1'b1) busy_err = 1'b1;
          if (m_k != 0 && fifo_rd !== 1'b0) rd_err = 1'b1;
          if (m_k % C == C - 1) begin
            if (!m_ghost)
              check($sformatf("bit%0d_of_%02h(err,txd)", m_k / C, m_e.d),
                    {bit_err, txd}, {1'b0, m_bits[m_k / C]});
            bit_err = 1'b0;
          end
          m_k++;
        end else begin
          if (!m_ghost) begin
            check($sformatf("frame_end_%02h(done,busy,txd)", m_e.d), {frame_done, busy, txd}, 3'b101);
            check($sformatf("busy_held_%02h", m_e.d), busy_err, 0);
            check($sformatf("single_pop_%02h", m_e.d), rd_err, 0);
          end
          last_end = cyc;
          m_act = 1'b0;
          m_ghost = 1'b0;
        end
      end
    end
  end

  task automatic wait_rd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (fifo_rd !== 1'b1 && n < 100);
    check("pop_seen", fifo_rd, 1);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || m_act) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("scoreboard_drained", (sb.size() == 0 && !m_act), 1);
  endtask

  initial begin
    int n;
    int p0;
    int fd;
    tx_en = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_txd", txd, 1);
    check("rst_busy", busy, 0);
    check("rst_fifo_rd", fifo_rd, 0);
    check("rst_frame_done", frame_done, 0);
    rst_n = 1'b1;

    // single bytes
    @(negedge clk);
    #1;
    p0 = pop_cnt;
    expect_frame(8'hA5, 1'b0, -1);
    push_fifo(8'hA5);
    wait_rd(n);
    check("start_latency_a5", n, 1);
    wait_idle(FL * 3);
    check("pops_a5", pop_cnt - p0, 1);

    p0 = pop_cnt;
    expect_frame(8'h07, 1'b1, -1);
    push_fifo(8'h07);
    wait_idle(FL * 3);
    check("pops_07", pop_cnt - p0, 1);

    // preloaded burst: back-to-back with a one-cycle gap
    p0 = pop_cnt;
    expect_frame(8'h11, 1'b0, -1);
    expect_frame(8'h22, 1'b0, 1);
    expect_frame(8'h33, 1'b0, 1);
    push_fifo(8'h11);
    push_fifo(8'h22);
    push_fifo(8'h33);
    wait_idle(FL * 5);
    repeat (3 * C) @(negedge clk);
    #1;
    check("pops_burst", pop_cnt - p0, 3);
    check("idle_after_burst_busy", busy, 0);

    // clear during data bit 3 (bit 3 of 0x52 is 0)
    mon_en = 1'b0;
    p0 = pop_cnt;
    push_fifo(8'h52);
    wait_rd(n);
    repeat (C + 3 * C + 1) @(negedge clk);
    #1;
    check("pre_clear_txd_bit3", txd, 0);
    clear = 1'b1;
    @(negedge clk);
    #1;
    check("clear_txd", txd, 1);
    check("clear_busy", busy, 0);
    check("clear_fifo_rd", fifo_rd, 0);
    clear = 1'b0;
    fd = 0;
    repeat (FL + 4) begin
      @(negedge clk);
      #1;
      if (frame_done === 1'b1) fd++;
    end
    check("no_done_after_clear", fd, 0);
    check("pops_clear", pop_cnt - p0, 1);
    mon_en = 1'b1;
    p0 = pop_cnt;
    expect_frame(8'hC1, 1'b1, -1);
    push_fifo(8'hC1);
    wait_idle(FL * 3);
    check("pops_after_clear", pop_cnt - p0, 1);

    // tx_en dropped during START with two bytes queued
    p0 = pop_cnt;
    expect_frame(8'h3C, 1'b0, -1);
    push_fifo(8'h3C);
    push_fifo(8'h96);
    wait_rd(n);
    tx_en = 1'b0;
    wait_idle(FL * 3);
    repeat (2 * C) @(negedge clk);
    #1;
    check("pops_txen_low", pop_cnt - p0, 1);
    check("txen_low_busy", busy, 0);
    expect_frame(8'h96, 1'b0, -1);
    tx_en = 1'b1;
    @(negedge clk);
    #1;
    check("txen_restart_pop", fifo_rd, 1);
    check("txen_restart_txd", txd, 0);
    wait_idle(FL * 3);
    check("pops_txen_total", pop_cnt - p0, 2);

    // asynchronous reset during the stop bit
    mon_en = 1'b0;
    p0 = pop_cnt;
    push_fifo(8'hF0);
    wait_rd(n);
    repeat ((9 + PB) * C + 1) @(negedge clk);
    #1;
    check("pre_reset_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_txd", txd, 1);
    check("async_rst_busy", busy, 0);
    check("async_rst_fifo_rd", fifo_rd, 0);
    check("async_rst_frame_done", frame_done, 0);
    push_fifo(8'h0F);
    repeat (4) @(negedge clk);
    #1;
    check("no_pop_in_reset", pop_cnt - p0, 1);
    expect_frame(8'h0F, 1'b0, -1);
    mon_en = 1'b1;
    rst_n = 1'b1;
    wait_rd(n);
    check("post_reset_latency", n, 1);
    wait_idle(FL * 3);
    check("pops_reset_total", pop_cnt - p0, 2);

    repeat (4) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
